// File: rtl/bus_pkg.sv
// Shared definitions for the bus-attached counter: default width, the
// default data type and the next-count/rollover rule used by the core.
package bus_pkg;

   localparam int DATA_W_DEF = 8;

   typedef logic [DATA_W_DEF-1:0] data_t;

   // Result of one clock step: the next count (masked to the active width)
   // and whether this step rolled the count over to zero.
   typedef struct packed {
      logic [31:0] cnt;
      logic        wrap;
   } step_t;

   // Next count and rollover flag for a counter of 'width' bits (1..32).
   // An enable that is not a clean 1 takes the else branch, so X/Z holds.
   function automatic step_t next_count(input logic [31:0] cnt,
                                        input int unsigned width,
                                        input logic        en);
      step_t       r;
      logic [31:0] mask;
      mask   = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      r.cnt  = cnt & mask;
      r.wrap = 1'b0;
      if (en) begin
         r.wrap = ((cnt & mask) == mask);
         r.cnt  = (cnt + 32'd1) & mask;
      end
      return r;
   endfunction

endpackage

// File: rtl/bus_if.sv
// Bus carrying the counter's control inputs and published outputs.
// The clock enters as an interface port; everything else is a variable.
interface bus_if #(parameter int DATA_W = 8) (input logic clk);

   logic              rst;
   logic              enable;
   logic [DATA_W-1:0] data;
   logic              wrap;

   modport DUT (
      input  clk,
      input  rst,
      input  enable,
      output data,
      output wrap
   );

   modport TB (
      input  clk,
      output rst,
      output enable,
      input  data,
      input  wrap
   );

endinterface

// File: rtl/bus_counter_core.sv
// Enable-gated up-counter with a one-cycle rollover pulse. Both outputs
// are registered and cleared asynchronously by rst.
module bus_counter_core
   import bus_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   output logic [DATA_W-1:0] data,
   output logic              wrap
);

   logic [DATA_W-1:0] cnt_p0;
   logic              wrap_p0;
   step_t             nxt;

   // The shared step function works on 32 bits; only the low DATA_W bits
   // of its count are registered, the rest is always zero.
   logic              unused_nxt;

   // Next-state calculation from the current count and enable.
   always_comb begin
      nxt        = next_count(32'(cnt_p0), DATA_W, enable);
      unused_nxt = ^nxt;
   end

   // Count register and rollover pulse; reset clears both at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_p0  <= '0;
         wrap_p0 <= 1'b0;
      end else begin
         cnt_p0  <= nxt.cnt[DATA_W-1:0];
         wrap_p0 <= nxt.wrap;
      end
   end

   assign data = cnt_p0;
   assign wrap = wrap_p0;

   // Simulation check: an unknown enable outside reset is a stimulus bug.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!$isunknown(enable))
            else $warning("bus_counter_core: enable is X/Z outside reset");
      end
   end

endmodule

// File: rtl/bus_counter.sv
// Bus-attached counter peripheral: unpacks the DUT modport onto the core.
module bus_counter
   import bus_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   bus_if.DUT bus
);

   bus_counter_core #(
      .DATA_W (DATA_W)
   ) u_core (
      .clk    (bus.clk),
      .rst    (bus.rst),
      .enable (bus.enable),
      .data   (bus.data),
      .wrap   (bus.wrap)
   );

endmodule

// File: tb/tb_bus_counter.sv
// Scoreboard bench for bus_counter: an 8-bit and a 4-bit instance share
// one stimulus stream; a reference model counts enabled edges since reset
// and derives the expected count and rollover pulse for each width.
module tb_bus_counter;

   logic clk = 1'b0;
   logic rst_s = 1'b1;
   logic en_s = 1'b1;

   bus_if #(.DATA_W(8)) bif8 (.clk(clk));
   bus_if #(.DATA_W(4)) bif4 (.clk(clk));

   assign bif8.rst    = rst_s;
   assign bif8.enable = en_s;
   assign bif4.rst    = rst_s;
   assign bif4.enable = en_s;

   bus_counter #(.DATA_W(8)) dut8 (.bus(bif8));
   bus_counter #(.DATA_W(4)) dut4 (.bus(bif4));

   typedef struct {
      int d8;
      int w8;
      int d4;
      int w4;
      int ph;
   } exp_t;

   exp_t q[$];
   event chk_ev;

   int total  = 0;
   int passed = 0;
   int phase  = 0;

   // reference model state
   int n      = 0;   // enabled edges since last reset
   int roll8  = 0;   // expected rollovers, whole run
   int roll4  = 0;
   int obs_w8 = 0;   // observed wrap pulses, whole run
   int obs_w4 = 0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input int ph, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s (phase %0d): got %0d, expected %0d", name, ph, act, exp);
   endtask

   // Reference model: react to every clock edge and every reset assertion.
   initial begin : model
      exp_t e;
      bit   en_now;
      forever begin
         @(posedge clk or posedge rst_s);
         en_now = (en_s === 1'b1);
         e.w8 = 0;
         e.w4 = 0;
         if (rst_s) begin
            n = 0;
         end else if (en_now) begin
            n++;
            e.w8 = (n % 256 == 0) ? 1 : 0;
            e.w4 = (n % 16 == 0) ? 1 : 0;
            roll8 += e.w8;
            roll4 += e.w4;
         end
         e.d8 = n % 256;
         e.d4 = n % 16;
         e.ph = phase;
         #1;
         q.push_back(e);
         -> chk_ev;
      end
   end

   // Monitor: compare DUT outputs against every queued expectation.
   initial begin : monitor
      exp_t e;
      forever begin
         @(chk_ev);
         while (q.size() > 0) begin
            e = q.pop_front();
            chk("data8", e.ph, longint'(bif8.data), e.d8);
            chk("wrap8", e.ph, longint'(bif8.wrap), e.w8);
            chk("data4", e.ph, longint'(bif4.data), e.d4);
            chk("wrap4", e.ph, longint'(bif4.wrap), e.w4);
            if (bif8.wrap) obs_w8++;
            if (bif4.wrap) obs_w4++;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   // Called at a falling edge: set enable for the next rising edge.
   task automatic step(input logic e);
      en_s = e;
      @(negedge clk);
   endtask

   // Called at a falling edge: 3 ns reset pulse between edges.
   task automatic rst_pulse(input logic e);
      en_s = e;
      #1 rst_s = 1'b1;
      #3 rst_s = 1'b0;
      @(negedge clk);
   endtask

   initial begin : driver
      // Reset held over two enabled edges.
      phase = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_s = 1'b0;

      // Count up from release: 1,2,3,... through the 4-bit rollover 15,0,1.
      phase = 1;
      repeat (17) step(1'b1);

      // Enable pattern from zero.
      phase = 2;
      rst_pulse(1'b0);
      step(1'b0); step(1'b1); step(1'b0); step(1'b1); step(1'b1); step(1'b0);

      // Reset mid-count at 37, then resume.
      phase = 3;
      rst_pulse(1'b0);
      repeat (37) step(1'b1);
      rst_pulse(1'b1);
      step(1'b1);

      // Random enable.
      phase = 4;
      rst_pulse(1'b0);
      for (int i = 0; i < 1000; i++) step(1'($urandom_range(0, 1)));

      // Unknown enable for one cycle.
      phase = 5;
      step(1'b1);
      step(1'bx);
      step(1'b0);
      step(1'b1);
      step(1'b0);

      @(negedge clk);
      chk("wrap8_total", 6, obs_w8, roll8);
      chk("wrap4_total", 6, obs_w4, roll4);
      chk("queue_drained", 6, q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/bus_counter.md
# bus_counter

Enable-gated up-counter that publishes its count on a shared bus interface. The bench clock drives it; a single `enable` qualifier advances it, and `data` is continuously readable by any bus observer. It serves as the reference bus-attached peripheral for interface/modport exercises.

## Interface

Connection is through a single modport `DUT` of interface `bus_if`. The interface carries the clock as an interface port; every other signal is an interface variable.

- One clock; reset is asynchronous and active-high.

Parameters:
- `DATA_W`, default 8: width of `data`, legal range 1..32.

Ports (directions as seen by the DUT modport):
- `clk`, input, 1 bit: rising-edge clock; interface port, sourced by the bench.
- `rst`, input, 1 bit: asynchronous, active-high reset.
- `enable`, input, 1 bit: count-advance qualifier, sampled on rising `clk`.
- `data`, output, DATA_W bits: current count, unsigned, registered.
- `wrap`, output, 1 bit: one-cycle registered pulse on count rollover.

## Operation

- Reset (`rst`=1):
  - `data` = 0 and `wrap` = 0 immediately, without waiting for a clock edge.
  - Both outputs hold those values while `rst` is high, regardless of `enable`.
- Rising `clk` with `rst`=0 and `enable`=1:
  - `data` ← (`data` + 1) mod 2^DATA_W.
  - `wrap` ← 1 if the old `data` = 2^DATA_W−1, else 0.
- Rising `clk` with `rst`=0 and `enable`=0:
  - `data` holds its value.
  - `wrap` ← 0.
- `enable` at X or Z: treat as 0, so `data` holds. Add a simulation-only assertion that flags any X on `enable` outside reset.
- Arithmetic: unsigned, modulo 2^DATA_W. No saturation, no down-count.
- Width: with DATA_W=1, `data` toggles on every enabled edge, and `wrap` pulses on each 1→0 transition.

## Timing

- Latency: `data` changes on the first rising `clk` at which `enable`=1 is sampled. One edge produces one increment.
- `enable` changes between edges have no effect until the next rising edge; there is no combinational path from `enable` to `data`.
- `wrap` is high for exactly the cycle after the edge that rolled `data` over to 0. It coincides with `data`=0.
- Reset assertion mid-count: outputs clear asynchronously within the same time step. An in-flight increment is discarded.
- Reset deassertion:
  - Deassert on or away from a falling edge.
  - The first rising edge with `rst`=0 and `enable`=1 produces `data`=1.
  - If `rst` falls coincident with a rising edge, that edge performs no increment.
- No handshake, no stall, no back-pressure.

## Structure

- Package `bus_pkg` holds:
  - `localparam int DATA_W_DEF = 8`;
  - `typedef logic [DATA_W_DEF-1:0] data_t`;
  - a `function automatic` for the next-count/wrap calculation, shared by RTL and the bench scoreboard.
- Interface `bus_if #(DATA_W)(input logic clk)`:
  - signals `rst`, `enable`, `data`, `wrap`;
  - modport `DUT`: input `clk`, `rst`, `enable`; output `data`, `wrap`;
  - modport `TB` with the mirrored directions;
  - an optional clocking block for the bench.
- Sub-module `bus_counter_core`:
  - a plain-port counter register with parameter DATA_W;
  - instantiated by `bus_counter`, which only unpacks the modport.

## Test plan

Bench: `clk` period 10 ns, DATA_W=8 unless noted; the scoreboard compares against the package function every cycle.

- **Reset:** hold `rst`=1 for 2 cycles with `enable`=1 → `data`=0 and `wrap`=0 throughout. Release with `enable`=1 → `data` is 1, 2, 3 on successive edges.
- **Enable pattern:** `enable` sequence 0,1,0,1,1,0 (one per cycle) from `data`=0 → `data` after each edge is 0,1,1,2,3,3.
- **Rollover (DATA_W=4):** preload to 14 via enabled counting, then enable 3 more cycles → `data` 15, 0, 1, with `wrap`=1 only in the cycle where `data`=0.
- **Reset mid-operation:** at `data`=37, pulse `rst` for 3 ns between edges → `data`=0 immediately. The next enabled edge → 1.
- **Random enable:** `$urandom_range(0,1)` for 1000 cycles → the count equals the number of sampled-high cycles mod 256. `wrap` count equals the number of rollovers.
- **X on `enable`:** drive X for 1 cycle → `data` unchanged and the assertion fires.
